// File: rtl/alinea_entrada.sv
// Sign-extends an 18-bit operand to 60 bits and shifts it left by a code, iteratively.
// Optional macro ALINEA_FAST_EN: shift 4 bits per cycle while at least 4 remain.
module alinea_entrada #(
  parameter int DW   = 18,
  parameter int AW   = 60,
  parameter int SW   = 6,
  parameter int SMAX = 42
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] x_i,
  input  logic [SW-1:0] s_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] y_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [SW-1:0] SMAX_C = SW'(SMAX);
  localparam logic [SW-1:0] ONE_C  = SW'(1);
`ifdef ALINEA_FAST_EN
  localparam logic [SW-1:0] FOUR_C = SW'(4);
`endif

  state_t        state;
  logic [AW-1:0] y_q;
  logic          err_q;
  logic [SW-1:0] cnt_q;
  logic [AW-1:0] x_sext;

  assign x_sext = {{(AW-DW){x_i[DW-1]}}, x_i};

  // Handshake flags decode the state register directly.
  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == HOLD);
  assign y_o         = y_q;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      y_q   <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            if (s_i > SMAX_C) begin
              y_q   <= '0;
              err_q <= 1'b1;
              state <= HOLD;
            end else if (s_i == '0) begin
              y_q   <= x_sext;
              err_q <= 1'b0;
              state <= HOLD;
            end else begin
              y_q   <= x_sext;
              cnt_q <= s_i;
              err_q <= 1'b0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
`ifdef ALINEA_FAST_EN
          if (cnt_q >= FOUR_C) begin
            y_q   <= y_q << 4;
            cnt_q <= cnt_q - FOUR_C;
            if (cnt_q == FOUR_C) state <= HOLD;
          end else begin
            y_q   <= y_q << 1;
            cnt_q <= cnt_q - ONE_C;
            if (cnt_q == ONE_C) state <= HOLD;
          end
`else
          y_q   <= y_q << 1;
          cnt_q <= cnt_q - ONE_C;
          if (cnt_q == ONE_C) state <= HOLD;
`endif
        end
        HOLD: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alinea_entrada.sv
// Directed and randomized self-checking bench for alinea_entrada.
module tb_alinea_entrada;

  logic        clk_i;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [17:0] x_i;
  logic [5:0]  s_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [59:0] y_o;
  logic        err_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  alinea_entrada dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .x_i(x_i),
    .s_i(s_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .y_o(y_o),
    .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int exp_latency(input int s);
`ifdef ALINEA_FAST_EN
    return 1 + s / 4 + s % 4;
`else
    return 1 + s;
`endif
  endfunction

  task automatic chk(input string name, input logic [59:0] got, input logic [59:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    else
      pass_cnt++;
  endtask

  // Presents one operand, returns edges from accept (inclusive) until out_valid_o.
  task automatic send(input logic [17:0] x, input logic [5:0] s, output int edges);
    @(negedge clk_i);
    in_valid_i = 1'b1;
    x_i = x;
    s_i = s;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    edges = 1;
    while (!out_valid_o && edges < 100) begin
      @(posedge clk_i);
      #1;
      edges++;
    end
  endtask

  task automatic finish_handshake();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("reset_y", y_o, 60'h0);
    chk("reset_err", {59'h0, err_o}, 60'h0);
    chk("reset_out_valid", {59'h0, out_valid_o}, 60'h0);
    chk("reset_in_ready", {59'h0, in_ready_o}, 60'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_zero_shift();
    int e;
    out_ready_i = 1'b0;
    send(18'h00001, 6'd0, e);
    chk("zero_latency", 60'(e), 60'd1);
    chk("zero_y", y_o, 60'h1);
    chk("zero_err", {59'h0, err_o}, 60'h0);
    finish_handshake();
    chk("zero_idle", {59'h0, in_ready_o}, 60'h1);
  endtask

  task automatic test_max_shift();
    int e;
    out_ready_i = 1'b0;
    send(18'h3FFFF, 6'd42, e);
    chk("max_latency", 60'(e), 60'(exp_latency(42)));
    chk("max_y", y_o, 60'hFFFFC0000000000);
    chk("max_err", {59'h0, err_o}, 60'h0);
    finish_handshake();
  endtask

  task automatic test_error();
    int e;
    out_ready_i = 1'b0;
    send(18'h1FFFF, 6'd43, e);
    chk("err_latency", 60'(e), 60'd1);
    chk("err_y", y_o, 60'h0);
    chk("err_flag", {59'h0, err_o}, 60'h1);
    finish_handshake();
    chk("err_in_ready", {59'h0, in_ready_o}, 60'h1);
    chk("err_out_valid_drop", {59'h0, out_valid_o}, 60'h0);
  endtask

  task automatic test_backpressure();
    int e;
    out_ready_i = 1'b0;
    send(18'h20000, 6'd5, e);
    chk("bp_latency", 60'(e), 60'(exp_latency(5)));
    in_valid_i = 1'b1;
    x_i = 18'h00007;
    s_i = 6'd1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1;
      chk("bp_y_stable", y_o, 60'hFFFFFFFFFC00000);
      chk("bp_in_ready", {59'h0, in_ready_o}, 60'h0);
      chk("bp_out_valid", {59'h0, out_valid_o}, 60'h1);
    end
    finish_handshake();
    in_valid_i = 1'b0;
    chk("bp_release_idle", {59'h0, in_ready_o}, 60'h1);
    chk("bp_release_valid", {59'h0, out_valid_o}, 60'h0);
  endtask

  task automatic test_reset_mid();
    int e;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b1;
    x_i = 18'h12345;
    s_i = 6'd20;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_y", y_o, 60'h0);
    chk("midrst_out_valid", {59'h0, out_valid_o}, 60'h0);
    chk("midrst_in_ready", {59'h0, in_ready_o}, 60'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    send(18'h00003, 6'd2, e);
    chk("midrst_next_latency", 60'(e), 60'(exp_latency(2)));
    chk("midrst_next_y", y_o, 60'hC);
    finish_handshake();
  endtask

  task automatic test_random_roundtrip();
    int e;
    logic [17:0] x;
    logic [5:0] s;
    logic signed [59:0] ys;
    logic signed [59:0] rec;
    logic signed [59:0] xs;
    out_ready_i = 1'b0;
    for (int n = 0; n < 500; n++) begin
      x = 18'($urandom);
      s = 6'($urandom_range(0, 42));
      send(x, s, e);
      ys  = y_o;
      rec = ys >>> s;
      xs  = {{42{x[17]}}, x};
      chk("rt_value", rec, xs);
      chk("rt_latency", 60'(e), 60'(exp_latency(int'(s))));
      finish_handshake();
      out_ready_i = 1'b0;
    end
  endtask

  initial begin
    rst_ni = 1'b1;
    in_valid_i = 1'b0;
    x_i = '0;
    s_i = '0;
    out_ready_i = 1'b0;
    test_reset();
    test_zero_shift();
    test_max_shift();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_random_roundtrip();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
